// File: rtl/dmem_arbiter.sv
// Two-port req/gnt/ack arbiter sequencing single accesses onto a synchronous-read memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_port;
  logic   w_grant;
  logic   w_win;
  logic   w_ack;
  logic   w_any_req;

`ifdef MEM_ARB_RR_EN
  logic   r_last;
`endif

  assign w_any_req = m0_req | m1_req;

  // Winner port id (0/1), only meaningful when w_grant is set.
  always_comb begin
    w_win = ~m0_req;
`ifdef MEM_ARB_RR_EN
    if (m0_req && m1_req) begin
      w_win = ~r_last;
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_ack       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_grant     = 1'b1;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_ack = 1'b1;
        if (w_any_req) begin
          w_grant     = 1'b1;
          w_state_nxt = S_ACCESS;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // mem_we/addr/wdata double as the command registers; the ack path reads
  // their pre-edge value, so a chained grant can overwrite them at the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_port    <= 1'b0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      m0_gnt  <= w_grant & ~w_win;
      m1_gnt  <= w_grant & w_win;
      mem_en  <= w_grant;
      m0_ack  <= w_ack & ~r_port;
      m1_ack  <= w_ack & r_port;
      if (w_ack && !mem_we) begin
        if (r_port) begin
          m1_rdata <= mem_rdata;
        end else begin
          m0_rdata <= mem_rdata;
        end
      end
      if (w_grant) begin
        r_port    <= w_win;
        mem_we    <= w_win ? m1_we    : m0_we;
        mem_addr  <= w_win ? m1_addr  : m0_addr;
        mem_wdata <= w_win ? m1_wdata : m0_wdata;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= 1'b1;
    end else if (w_grant) begin
      r_last <= w_win;
    end
  end
`endif

  assign busy = (r_state != S_IDLE);

endmodule
